bus_interconnect: RTL and testbench

//  Parametrised successor to the fixed two-way RAM/IO mux. Connects the single CPU data-bus master to NUM_SLAVES memory-mapped slaves.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_addr_decoder.sv | 30 +++
 rtl/bus_interconnect.sv | 175 +++++++++++++++++
 tb/tb_bus_interconnect.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU data-bus interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } bus_state_e;

  localparam logic [3:0] RegRam = 4'h0;
  localparam logic [3:0] RegIo  = 4'h1;

  localparam logic [2:0] RwB  = 3'b000;
  localparam logic [2:0] RwH  = 3'b001;
  localparam logic [2:0] RwW  = 3'b010;
  localparam logic [2:0] RwBu = 3'b100;
  localparam logic [2:0] RwHu = 3'b101;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Region decoder: compares the address region field with each slave's region id.
// Priority-encoded so the lowest matching slave index wins.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int unsigned               NUM_SLAVES = 4,
  parameter int unsigned               RW         = 4,
  parameter int unsigned               IdxW       = 2,
  parameter logic [NUM_SLAVES*4-1:0]   REGION_ID  = '0
) (
  input  logic [RW-1:0]         region_i,
  output logic [NUM_SLAVES-1:0] hit_vec_o,
  output logic                  hit_o,
  output logic [IdxW-1:0]       idx_o
);

  always_comb begin
    hit_vec_o = '0;
    hit_o     = 1'b0;
    idx_o     = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_o && (region_i == RW'(REGION_ID[i*4 +: 4]))) begin
        hit_o        = 1'b1;
        hit_vec_o[i] = 1'b1;
        idx_o        = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-master to NUM_SLAVES memory-mapped interconnect with req/ready handshake,
// registered response, and bus error on decode miss or slave timeout.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned             DW         = 32,
  parameter int unsigned             AW         = 32,
  parameter int unsigned             NUM_SLAVES = 4,
  parameter int unsigned             SEL_LSB    = 28,
  parameter int unsigned             LOCAL_AW   = 24,
  parameter logic [NUM_SLAVES*4-1:0] REGION_ID  = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter int unsigned             TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_req,
  input  logic                     m_we,
  input  logic [AW-1:0]            m_addr,
  input  logic [2:0]               m_rw_type,
  input  logic [DW-1:0]            m_wdata,
  output logic                     m_ready,
  output logic [DW-1:0]            m_rdata,
  output logic                     m_err,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic                     s_we,
  output logic [AW-1:0]            s_addr,
  output logic [2:0]               s_rw_type,
  output logic [DW-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*DW-1:0] s_rdata,
  output logic [AW-1:0]            err_addr
);

  localparam int unsigned IdxW       = idx_width(NUM_SLAVES);
  localparam int unsigned RW         = AW - SEL_LSB;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  bus_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW-1:0]         acc_addr_q, acc_addr_d;
  logic [2:0]            rw_type_q, rw_type_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [AW-1:0]         err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0] dec_vec;
  logic                  dec_hit;
  logic [IdxW-1:0]       dec_idx;
  logic [DW-1:0]         slave_rdata;
  logic                  slave_ready;

  bus_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .RW        (RW),
    .IdxW      (IdxW),
    .REGION_ID (REGION_ID)
  ) u_decoder (
    .region_i (m_addr[AW-1:SEL_LSB]),
    .hit_vec_o(dec_vec),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx)
  );

  // sel_q is one-hot during ACCESS, so this masks out unselected slaves.
  assign slave_ready = |(s_ready & sel_q);

  always_comb begin
    slave_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IdxW'(i)) slave_rdata = s_rdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    acc_addr_d = acc_addr_q;
    rw_type_d  = rw_type_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      StIdle: begin
        if (m_req) begin
          if (dec_hit) begin
            sel_d      = dec_vec;
            we_d       = m_we;
            addr_d     = AW'(m_addr[LOCAL_AW-1:0]);
            acc_addr_d = m_addr;
            rw_type_d  = m_rw_type;
            wdata_d    = m_wdata;
            idx_d      = dec_idx;
            cnt_d      = '0;
            state_d    = StAccess;
          end else begin
            rdata_d    = '0;
            err_d      = 1'b1;
            err_addr_d = m_addr;
            state_d    = StResp;
          end
        end
      end
      StAccess: begin
        if (slave_ready) begin
          rdata_d = we_q ? '0 : slave_rdata;
          err_d   = 1'b0;
          sel_d   = '0;
          state_d = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          // Full address kept so the reported error address retains the region.
          rdata_d    = '0;
          err_d      = 1'b1;
          err_addr_d = acc_addr_q;
          sel_d      = '0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      acc_addr_q <= '0;
      rw_type_q  <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      acc_addr_q <= acc_addr_d;
      rw_type_q  <= rw_type_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign m_ready   = (state_q == StResp);
  assign m_rdata   = rdata_q;
  assign m_err     = err_q;
  assign s_sel     = sel_q;
  assign s_we      = we_q;
  assign s_addr    = addr_q;
  assign s_rw_type = rw_type_q;
  assign s_wdata   = wdata_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed corner cases plus randomized
// accesses checked against a transaction-level latency/response model.
module tb_bus_interconnect;
  import bus_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [2:0]   m_rw_type;
  logic [31:0]  m_wdata;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [2:0]   s_rw_type;
  logic [31:0]  s_wdata;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic [31:0]  err_addr;

  int n_asserts;
  int n_fail;
  logic [31:0] exp_err_addr;
  logic [3:0]  region_ids [4] = '{4'h0, 4'h1, 4'h2, 4'h3};

  always #5 clk = ~clk;

  bus_interconnect dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_rw_type(m_rw_type),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_rw_type(s_rw_type),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .err_addr (err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_slave(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a[31:28] == region_ids[i]) return i;
    end
    return -1;
  endfunction

  // One transaction; the selected slave raises s_ready after `w` wait states.
  task automatic access(input logic [31:0] addr, input logic we, input logic [2:0] rw,
                        input logic [31:0] wdata, input int w, input logic [31:0] rd);
    int          k;
    int          exp_lat;
    int          lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  onehot;
    k       = find_slave(addr);
    onehot  = (k >= 0) ? (4'b0001 << k) : 4'b0000;
    exp_lat = (k < 0) ? 1 : ((w <= 255) ? 2 + w : 257);
    exp_err = (k < 0) || (w > 255);
    exp_rdata = (!exp_err && !we) ? rd : 32'h0;
    if (exp_err) exp_err_addr = addr;

    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_rw_type = rw; m_wdata = wdata;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 300 && lat == 0; c++) begin
      @(negedge clk);
      m_addr  = $urandom;
      m_wdata = $urandom;
      m_we    = 1'($urandom);
      if (c == 1 && k >= 0) begin
        chk("s_addr", s_addr, {8'h00, addr[23:0]});
        chk("s_we", s_we, we);
        chk("s_wdata", s_wdata, wdata);
        chk("s_rw_type", s_rw_type, rw);
      end
      if (m_ready) begin
        lat = c;
        chk("sel_clear_in_resp", s_sel, 4'b0000);
      end else begin
        chk("sel_held", s_sel, onehot);
      end
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      s_ready = 4'($urandom) & ~onehot;
      if (k >= 0 && c - 1 == w) begin
        s_ready[k] = 1'b1;
        s_rdata[k*32 +: 32] = rd;
      end
    end
    m_req   = 1'b0;
    s_ready = 4'b0000;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("m_err", m_err, exp_err);
    chk("m_rdata", m_rdata, exp_rdata);
    chk("err_addr", err_addr, exp_err_addr);
    @(negedge clk);
    chk("ready_one_cycle", m_ready, 1'b0);
    chk("m_rdata_hold", m_rdata, exp_rdata);
    chk("m_err_hold", m_err, exp_err);
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    exp_err_addr = 32'h0;
    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_rw_type = '0; m_wdata = '0;
    s_ready = '0; s_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", m_ready, 1'b0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_m_err", m_err, 1'b0);
    chk("rst_s_sel", s_sel, 4'b0000);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(32'h0000_0010, 1'b0, RwW, 32'h0, 0, 32'h1234_5678);
    access(32'h1000_0004, 1'b1, RwB, 32'h0000_00A5, 3, 32'hDEAD_BEEF);
    access(32'hF000_0000, 1'b0, RwW, 32'h0, 0, 32'h5555_AAAA);
    access(32'h2000_1234, 1'b0, RwH, 32'h0, 400, 32'h0BAD_0BAD);
    access(32'h3000_0008, 1'b0, RwHu, 32'h0, 255, 32'hCAFE_F00D);
    access(32'h5123_4567, 1'b1, RwBu, 32'h7777_7777, 0, 32'h0);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h2000_0040; m_rw_type = RwW;
    @(posedge clk);
    repeat (4) @(negedge clk);
    chk("rst_mid_sel_before", s_sel, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", s_sel, 4'b0000);
    chk("rst_mid_ready", m_ready, 1'b0);
    chk("rst_mid_err_addr", err_addr, 32'h0);
    m_req = 1'b0;
    exp_err_addr = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ready", m_ready, 1'b0);
    end
    access(32'h2000_0040, 1'b0, RwW, 32'h0, 1, 32'h0246_8ACE);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      int          w;
      a = $urandom;
      a[31:28] = 4'($urandom_range(0, 5));
      if (i % 11 == 10) a[31:28] = 4'hF;
      w = (i % 13 == 12) ? 300 : $urandom_range(0, 5);
      access(a, 1'($urandom), 3'($urandom), $urandom, w, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
